// File: rtl/dcache_port_arbiter_pkg.sv
// Shared IDs and SRAM-like size codes for the dcache port arbiter.
package dcache_port_arbiter_pkg;
    localparam logic MID_M0 = 1'b0;
    localparam logic MID_M1 = 1'b1;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;
endpackage

// File: rtl/dcache_port_arbiter_id_fifo.sv
// In-order owner-ID FIFO: one bit per accepted, unanswered request.
module dcache_port_arbiter_id_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        push_id,
    input  logic        pop,
    output logic        head_id,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);
    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH[AW:0]);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_id = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/dcache_port_arbiter.sv
// Two-master arbiter for the SRAM-like dcache port; an ID FIFO
// routes each data_ok back to the master that issued the request.
module dcache_port_arbiter
    import dcache_port_arbiter_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int FIXED_PRIO = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m0_req,
    input  logic                     m0_wr,
    input  logic [1:0]               m0_size,
    input  logic [31:0]              m0_addr,
    input  logic [31:0]              m0_wdata,
    input  logic [3:0]               m0_wstrb,
    output logic                     m0_addr_ok,
    output logic                     m0_data_ok,
    output logic [31:0]              m0_rdata,
    input  logic                     m1_req,
    input  logic                     m1_wr,
    input  logic [1:0]               m1_size,
    input  logic [31:0]              m1_addr,
    input  logic [31:0]              m1_wdata,
    input  logic [3:0]               m1_wstrb,
    output logic                     m1_addr_ok,
    output logic                     m1_data_ok,
    output logic [31:0]              m1_rdata,
    output logic                     s_req,
    output logic                     s_wr,
    output logic [1:0]               s_size,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    output logic [3:0]               s_wstrb,
    input  logic [31:0]              s_rdata,
    input  logic                     s_addr_ok,
    input  logic                     s_data_ok,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     err_unexp_data_ok
);
    logic grant;
    logic grant_req;
    logic lock_q;
    logic lock_id_q;
    logic rr_last_q;
    logic accept;
    logic pop;
    logic head_id;
    logic full;
    logic empty;

    always_comb begin
        grant = MID_M0;
        priority case (1'b1)
            lock_q:            grant = lock_id_q;
            (m0_req && m1_req): grant = (FIXED_PRIO != 0) ? MID_M0 : ~rr_last_q;
            m1_req:            grant = MID_M1;
            default:           grant = MID_M0;
        endcase
    end

    assign grant_req = (grant == MID_M1) ? m1_req : m0_req;
    assign s_req     = grant_req && !full;
    assign s_wr      = (grant == MID_M1) ? m1_wr    : m0_wr;
    assign s_size    = (grant == MID_M1) ? m1_size  : m0_size;
    assign s_addr    = (grant == MID_M1) ? m1_addr  : m0_addr;
    assign s_wdata   = (grant == MID_M1) ? m1_wdata : m0_wdata;
    assign s_wstrb   = (grant == MID_M1) ? m1_wstrb : m0_wstrb;

    assign accept     = s_req && s_addr_ok;
    assign m0_addr_ok = accept && (grant == MID_M0);
    assign m1_addr_ok = accept && (grant == MID_M1);

    // Only answers for entries already queued; the head is read pre-push.
    assign pop        = s_data_ok && !empty;
    assign m0_data_ok = pop && (head_id == MID_M0);
    assign m1_data_ok = pop && (head_id == MID_M1);
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q            <= 1'b0;
            lock_id_q         <= MID_M0;
            rr_last_q         <= MID_M1;
            err_unexp_data_ok <= 1'b0;
        end else begin
            if (accept) begin
                lock_q    <= 1'b0;
                rr_last_q <= grant;
            end else if (s_req) begin
                lock_q    <= 1'b1;
                lock_id_q <= grant;
            end
            if (s_data_ok && empty) begin
                err_unexp_data_ok <= 1'b1;
            end
        end
    end

    dcache_port_arbiter_id_fifo #(
        .DEPTH(DEPTH)
    ) u_id_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (accept),
        .push_id(grant),
        .pop    (pop),
        .head_id(head_id),
        .full   (full),
        .empty  (empty),
        .count  (outstanding)
    );
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter (DEPTH=4, round-robin).
module tb_dcache_port_arbiter;
    import dcache_port_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 0, m0_wr = 0, m1_req = 0, m1_wr = 0;
    logic [1:0]  m0_size = SIZE_WORD, m1_size = SIZE_HALF;
    logic [31:0] m0_addr = 32'h100, m1_addr = 32'h200;
    logic [31:0] m0_wdata = 32'hA0A0, m1_wdata = 32'hB1B1;
    logic [3:0]  m0_wstrb = 4'hF, m1_wstrb = 4'h3;
    logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] s_rdata = 32'h0;
    logic        s_addr_ok = 0, s_data_ok = 0;
    logic [2:0]  outstanding;
    logic        err_unexp_data_ok;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dcache_port_arbiter #(.DEPTH(4), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
        .outstanding(outstanding), .err_unexp_data_ok(err_unexp_data_ok)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ok(input string tag, input logic a0, input logic a1,
                          input logic d0, input logic d1);
        chk({tag, ".m0_addr_ok"}, 32'(m0_addr_ok), 32'(a0));
        chk({tag, ".m1_addr_ok"}, 32'(m1_addr_ok), 32'(a1));
        chk({tag, ".m0_data_ok"}, 32'(m0_data_ok), 32'(d0));
        chk({tag, ".m1_data_ok"}, 32'(m1_data_ok), 32'(d1));
    endtask

    initial begin
        // reset state
        #2;
        chk("rst.outstanding", 32'(outstanding), 0);
        chk("rst.err", 32'(err_unexp_data_ok), 0);
        chk_ok("rst", 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;

        // round-robin with immediate data return
        m0_req = 1; m1_req = 1; s_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            s_data_ok = (i > 0);
            #1;
            chk("rr.s_addr", s_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
            chk("rr.s_size", 32'(s_size), (i % 2 == 0) ? 32'd2 : 32'd1);
            chk("rr.outstanding", 32'(outstanding), (i > 0) ? 1 : 0);
            chk_ok("rr", (i % 2 == 0), (i % 2 == 1),
                   (i > 0) && (i % 2 == 1), (i > 0) && (i % 2 == 0));
            @(negedge clk);
        end
        m0_req = 0; m1_req = 0; s_data_ok = 1;
        #1;
        chk_ok("rr.tail", 0, 0, 0, 1);
        @(negedge clk);
        s_data_ok = 0;
        #1;
        chk("rr.drained", 32'(outstanding), 0);

        // stalled M1 handshake keeps the lock while M0 arrives
        s_addr_ok = 0; m1_req = 1;
        #1;
        chk("lock.c1.s_addr", s_addr, 32'h200);
        chk_ok("lock.c1", 0, 0, 0, 0);
        @(negedge clk);
        m0_req = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("lock.held.s_addr", s_addr, 32'h200);
            chk("lock.held.s_wdata", s_wdata, 32'hB1B1);
            chk_ok("lock.held", 0, 0, 0, 0);
            @(negedge clk);
        end
        s_addr_ok = 1;
        #1;
        chk("lock.c4.s_addr", s_addr, 32'h200);
        chk_ok("lock.c4", 0, 1, 0, 0);
        @(negedge clk);
        #1;
        chk("lock.c5.s_addr", s_addr, 32'h100);
        chk_ok("lock.c5", 1, 0, 0, 0);
        @(negedge clk);
        m0_req = 0; m1_req = 0; s_data_ok = 1;
        #1;
        chk("lock.out", 32'(outstanding), 2);
        chk_ok("lock.d1", 0, 0, 0, 1);
        @(negedge clk);
        #1;
        chk_ok("lock.d2", 0, 0, 1, 0);
        @(negedge clk);
        s_data_ok = 0;

        // fill the FIFO, then a held M1 request waits for space
        m0_req = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("full.fill", 32'(m0_addr_ok), 1);
            @(negedge clk);
        end
        m0_req = 0; m1_req = 1;
        #1;
        chk("full.outstanding", 32'(outstanding), 4);
        chk("full.s_req", 32'(s_req), 0);
        chk_ok("full.c5", 0, 0, 0, 0);
        @(negedge clk);
        s_data_ok = 1;
        #1;
        chk("full.pop.s_req", 32'(s_req), 0);
        chk_ok("full.pop", 0, 0, 1, 0);
        @(negedge clk);
        s_data_ok = 0;
        #1;
        chk("full.after.outstanding", 32'(outstanding), 3);
        chk("full.after.s_req", 32'(s_req), 1);
        chk_ok("full.after", 0, 1, 0, 0);
        @(negedge clk);
        m1_req = 0; s_data_ok = 1;
        @(negedge clk);
        @(negedge clk);
        s_data_ok = 0;
        #1;
        chk("pp.pre", 32'(outstanding), 2);

        // same-cycle push and pop: data_ok to the older owner
        m1_req = 1; s_data_ok = 1;
        #1;
        chk_ok("pp", 0, 1, 1, 0);
        @(negedge clk);
        m1_req = 0;
        #1;
        chk("pp.post", 32'(outstanding), 2);
        chk_ok("pp.d1", 0, 0, 0, 1);
        @(negedge clk);
        #1;
        chk_ok("pp.d2", 0, 0, 0, 1);
        @(negedge clk);

        // unexpected data_ok with FIFO empty
        #1;
        chk("unexp.outstanding", 32'(outstanding), 0);
        chk("unexp.err.pre", 32'(err_unexp_data_ok), 0);
        chk_ok("unexp", 0, 0, 0, 0);
        @(negedge clk);
        s_data_ok = 0;
        #1;
        chk("unexp.err", 32'(err_unexp_data_ok), 1);
        @(negedge clk);
        #1;
        chk("unexp.sticky", 32'(err_unexp_data_ok), 1);

        // async reset with 3 in flight
        m0_req = 1;
        for (int i = 0; i < 3; i++) @(negedge clk);
        m0_req = 0;
        #1;
        chk("ar.pre", 32'(outstanding), 3);
        rst = 1;
        #1;
        chk("ar.outstanding", 32'(outstanding), 0);
        chk("ar.err", 32'(err_unexp_data_ok), 0);
        @(negedge clk);
        rst = 0;
        s_data_ok = 1;
        #1;
        chk_ok("ar.stale", 0, 0, 0, 0);
        @(negedge clk);
        s_data_ok = 0;
        #1;
        chk("ar.stale.err", 32'(err_unexp_data_ok), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
